// File: rtl/tvip_axi_types_pkg.sv
// Shared AXI4 types for the tvip_axi agents and the RAM responder:
// field widths, burst/response encodings and the per-beat address step.
package tvip_axi_types_pkg;

    localparam int TVIP_AXI_ID_WIDTH      = 4;
    localparam int TVIP_AXI_ADDRESS_WIDTH = 32;
    localparam int TVIP_AXI_DATA_WIDTH    = 32;
    localparam int TVIP_AXI_STROBE_WIDTH  = TVIP_AXI_DATA_WIDTH / 8;

    typedef logic [TVIP_AXI_ID_WIDTH-1:0]      tvip_axi_id;
    typedef logic [TVIP_AXI_ADDRESS_WIDTH-1:0] tvip_axi_address;
    typedef logic [7:0]                        tvip_axi_burst_length;
    typedef logic [2:0]                        tvip_axi_burst_size;
    typedef logic [3:0]                        tvip_axi_cache;
    typedef logic [2:0]                        tvip_axi_prot;
    typedef logic [3:0]                        tvip_axi_qos;
    typedef logic [TVIP_AXI_DATA_WIDTH-1:0]    tvip_axi_data;
    typedef logic [TVIP_AXI_STROBE_WIDTH-1:0]  tvip_axi_strobe;

    typedef enum logic [1:0] {
        TVIP_AXI_FIXED_BURST        = 2'b00,
        TVIP_AXI_INCREMENTING_BURST = 2'b01,
        TVIP_AXI_WRAPPING_BURST     = 2'b10,
        TVIP_AXI_RESERVED_BURST     = 2'b11
    } tvip_axi_burst_type;

    typedef enum logic [1:0] {
        TVIP_AXI_OKAY         = 2'b00,
        TVIP_AXI_EXOKAY       = 2'b01,
        TVIP_AXI_SLAVE_ERROR  = 2'b10,
        TVIP_AXI_DECODE_ERROR = 2'b11
    } tvip_axi_response;

    // Byte address of the beat following addr; WRAP assumes a legal (power-of-two) length.
    function automatic tvip_axi_address tvip_axi_next_address(
        input tvip_axi_address      addr,
        input tvip_axi_burst_size   size,
        input tvip_axi_burst_length len,
        input tvip_axi_burst_type   burst
    );
        tvip_axi_address bytes;
        tvip_axi_address aligned;
        tvip_axi_address boundary;
        tvip_axi_address lower;
        tvip_axi_address result;
        bytes    = tvip_axi_address'(1) << size;
        aligned  = addr & ~(bytes - tvip_axi_address'(1));
        boundary = (tvip_axi_address'(len) + tvip_axi_address'(1)) << size;
        lower    = addr & ~(boundary - tvip_axi_address'(1));
        case (burst)
            TVIP_AXI_FIXED_BURST:    result = addr;
            TVIP_AXI_WRAPPING_BURST: result = lower | ((aligned + bytes) & (boundary - tvip_axi_address'(1)));
            default:                 result = aligned + bytes;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tvip_axi_burst_addr_gen.sv
// Per-channel burst address tracker: yields the current and next-cycle RAM word index
// plus burst-level SLVERR and per-beat out-of-range flags (TVIP_AXI_RAM_RESPONDER_DECERR_EN).
module tvip_axi_burst_addr_gen
    import tvip_axi_types_pkg::*;
#(
    parameter int              DATA_WIDTH  = 32,
    parameter int              DEPTH       = 1024,
    parameter tvip_axi_address BASE_ADDR   = '0,
    parameter int              INDEX_WIDTH = $clog2(DEPTH)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   load,
    input  logic                   advance,
    input  tvip_axi_address        addr,
    input  tvip_axi_burst_length   len,
    input  tvip_axi_burst_size     size,
    input  tvip_axi_burst_type     burst,
    output logic [INDEX_WIDTH-1:0] index,
    output logic [INDEX_WIDTH-1:0] index_next,
    output logic                   oor,
    output logic                   oor_next,
    output logic                   slverr,
    output logic                   slverr_next
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);

    tvip_axi_address      addr_q;
    tvip_axi_address      addr_d;
    tvip_axi_burst_length len_q;
    tvip_axi_burst_size   size_q;
    tvip_axi_burst_type   burst_q;
    logic                 slverr_q;

    function automatic logic [INDEX_WIDTH-1:0] to_index(input tvip_axi_address a);
        tvip_axi_address offset;
        offset = a - BASE_ADDR;
        return INDEX_WIDTH'(offset >> BYTE_SHIFT);
    endfunction

    function automatic logic burst_error(
        input tvip_axi_address      a,
        input tvip_axi_burst_length l,
        input tvip_axi_burst_size   s,
        input tvip_axi_burst_type   b
    );
        logic bad_type;
        logic bad_size;
        logic bad_wrap;
        tvip_axi_address bytes;
        bytes    = tvip_axi_address'(1) << s;
        bad_type = (b == TVIP_AXI_RESERVED_BURST);
        bad_size = bytes > tvip_axi_address'(BYTES);
        bad_wrap = (b == TVIP_AXI_WRAPPING_BURST) &&
                   (!(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15) ||
                    ((a & (bytes - tvip_axi_address'(1))) != '0));
        return bad_type || bad_size || bad_wrap;
    endfunction

`ifdef TVIP_AXI_RAM_RESPONDER_DECERR_EN
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'(BYTES);

    // Addresses below BASE_ADDR wrap to a huge offset and fail the same compare.
    function automatic logic out_of_range(input tvip_axi_address a);
        logic [32:0] offset;
        offset = {1'b0, a} - {1'b0, BASE_ADDR};
        return offset >= RAM_BYTES;
    endfunction

    assign oor      = out_of_range(addr_q);
    assign oor_next = out_of_range(addr_d);
`else
    assign oor      = 1'b0;
    assign oor_next = 1'b0;
`endif

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = addr;
        end else if (advance) begin
            addr_d = tvip_axi_next_address(addr_q, size_q, len_q, burst_q);
        end
    end

    assign index       = to_index(addr_q);
    assign index_next  = to_index(addr_d);
    assign slverr      = slverr_q;
    assign slverr_next = load ? burst_error(addr, len, size, burst) : slverr_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= TVIP_AXI_FIXED_BURST;
            slverr_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            slverr_q <= slverr_next;
            if (load) begin
                len_q   <= len;
                size_q  <= size;
                burst_q <= burst;
            end
        end
    end

endmodule

// File: rtl/tvip_axi_ram_responder.sv
// AXI4 slave backed by an inferred word RAM; one outstanding burst per direction.
// Define TVIP_AXI_RAM_RESPONDER_DECERR_EN to return DECERR for beats outside the RAM window.
//
//  state   | meaning
//  W_IDLE  | awready high, waiting for a write address
//  W_DATA  | wready high, accepting beats until the awlen-th
//  W_RESP  | bvalid high with accumulated bresp
//  R_IDLE  | arready high, waiting for a read address
//  R_DATA  | rvalid high, one beat presented per R handshake
module tvip_axi_ram_responder
    import tvip_axi_types_pkg::*;
#(
    parameter int              DATA_WIDTH = TVIP_AXI_DATA_WIDTH,
    parameter int              DEPTH      = 1024,
    parameter tvip_axi_address BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    awvalid,
    output logic                    awready,
    input  tvip_axi_id              awid,
    input  tvip_axi_address         awaddr,
    input  tvip_axi_burst_length    awlen,
    input  tvip_axi_burst_size      awsize,
    input  tvip_axi_burst_type      awburst,
    input  tvip_axi_cache           awcache,
    input  tvip_axi_prot            awprot,
    input  tvip_axi_qos             awqos,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output tvip_axi_id              bid,
    output tvip_axi_response        bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  tvip_axi_id              arid,
    input  tvip_axi_address         araddr,
    input  tvip_axi_burst_length    arlen,
    input  tvip_axi_burst_size      arsize,
    input  tvip_axi_burst_type      arburst,
    input  tvip_axi_cache           arcache,
    input  tvip_axi_prot            arprot,
    input  tvip_axi_qos             arqos,
    output logic                    rvalid,
    input  logic                    rready,
    output tvip_axi_id              rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output tvip_axi_response        rresp,
    output logic                    rlast
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                 active_q;
    logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs, r_fetch;
    tvip_axi_id           bid_q, rid_q;
    tvip_axi_burst_length w_cnt_q, r_cnt_q;
    logic                 wr_slv_q, wr_dec_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    tvip_axi_response     rresp_q;

    logic [IDX_W-1:0] w_idx, r_idx_next;
    logic             w_oor, w_slverr, r_oor_next, r_slverr_next;
    logic [IDX_W-1:0] unused_w_idx_next, unused_r_idx;
    logic             unused_w_oor_next, unused_w_slverr_next, unused_r_oor, unused_r_slverr;
    logic             unused_sideband;

    assign unused_sideband = ^{awcache, awprot, awqos, arcache, arprot, arqos};

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign b_hs    = bvalid && bready;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign r_fetch = ar_hs || (r_hs && (r_cnt_q != '0));

    tvip_axi_burst_addr_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_w_addr (
        .aclk        (aclk),
        .areset      (areset),
        .load        (aw_hs),
        .advance     (w_hs),
        .addr        (awaddr),
        .len         (awlen),
        .size        (awsize),
        .burst       (awburst),
        .index       (w_idx),
        .index_next  (unused_w_idx_next),
        .oor         (w_oor),
        .oor_next    (unused_w_oor_next),
        .slverr      (w_slverr),
        .slverr_next (unused_w_slverr_next)
    );

    tvip_axi_burst_addr_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_r_addr (
        .aclk        (aclk),
        .areset      (areset),
        .load        (ar_hs),
        .advance     (r_fetch),
        .addr        (araddr),
        .len         (arlen),
        .size        (arsize),
        .burst       (arburst),
        .index       (unused_r_idx),
        .index_next  (r_idx_next),
        .oor         (unused_r_oor),
        .oor_next    (r_oor_next),
        .slverr      (unused_r_slverr),
        .slverr_next (r_slverr_next)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = TVIP_AXI_OKAY;
        case (w_state_q)
            W_IDLE: begin
                awready = active_q;
                if (awvalid && active_q) w_state_d = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && (w_cnt_q == '0)) w_state_d = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = wr_dec_q ? TVIP_AXI_DECODE_ERROR :
                         wr_slv_q ? TVIP_AXI_SLAVE_ERROR  : TVIP_AXI_OKAY;
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready = active_q;
                if (arvalid && active_q) r_state_d = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && (r_cnt_q == '0)) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // active_q keeps every ready low for the cycle after reset is released.
    always_ff @(posedge aclk) begin
        if (areset) begin
            active_q <= 1'b0;
            bid_q    <= '0;
            w_cnt_q  <= '0;
            wr_slv_q <= 1'b0;
            wr_dec_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (aw_hs) begin
                bid_q    <= awid;
                w_cnt_q  <= awlen;
                wr_slv_q <= 1'b0;
                wr_dec_q <= 1'b0;
            end else if (w_hs) begin
                w_cnt_q <= w_cnt_q - 8'd1;
                if (w_slverr || (wlast != (w_cnt_q == '0))) wr_slv_q <= 1'b1;
                if (w_oor) wr_dec_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !areset && !w_slverr && !w_oor) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // The next beat is fetched on the handshake that retires the current one, so a
    // same-cycle write to that word is not yet visible (read-before-write).
    always_ff @(posedge aclk) begin
        if (areset) begin
            rid_q   <= '0;
            r_cnt_q <= '0;
            rdata_q <= '0;
            rresp_q <= TVIP_AXI_OKAY;
        end else begin
            if (ar_hs) begin
                rid_q   <= arid;
                r_cnt_q <= arlen;
            end else if (r_hs && (r_cnt_q != '0)) begin
                r_cnt_q <= r_cnt_q - 8'd1;
            end
            if (r_fetch) begin
                rdata_q <= (r_slverr_next || r_oor_next) ? '0 : mem[r_idx_next];
                rresp_q <= r_oor_next    ? TVIP_AXI_DECODE_ERROR :
                           r_slverr_next ? TVIP_AXI_SLAVE_ERROR  : TVIP_AXI_OKAY;
            end
        end
    end

    assign bid   = bid_q;
    assign rid   = rid_q;
    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign rlast = rvalid && (r_cnt_q == '0);

endmodule

// File: tb/tb_tvip_axi_ram_responder.sv
// Directed self-checking bench for tvip_axi_ram_responder (default 32-bit, 1024-word RAM);
// the out-of-range read expectation follows TVIP_AXI_RAM_RESPONDER_DECERR_EN.
module tb_tvip_axi_ram_responder;
    import tvip_axi_types_pkg::*;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic                 awvalid, awready;
    tvip_axi_id           awid;
    tvip_axi_address      awaddr;
    tvip_axi_burst_length awlen;
    tvip_axi_burst_size   awsize;
    tvip_axi_burst_type   awburst;
    tvip_axi_cache        awcache;
    tvip_axi_prot         awprot;
    tvip_axi_qos          awqos;
    logic                 wvalid, wready;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wlast;
    logic                 bvalid, bready;
    tvip_axi_id           bid;
    tvip_axi_response     bresp;
    logic                 arvalid, arready;
    tvip_axi_id           arid;
    tvip_axi_address      araddr;
    tvip_axi_burst_length arlen;
    tvip_axi_burst_size   arsize;
    tvip_axi_burst_type   arburst;
    tvip_axi_cache        arcache;
    tvip_axi_prot         arprot;
    tvip_axi_qos          arqos;
    logic                 rvalid, rready;
    tvip_axi_id           rid;
    logic [31:0]          rdata;
    tvip_axi_response     rresp;
    logic                 rlast;

    int total = 0;
    int bad   = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrespbuf [16];
    logic        rlastbuf [16];
    logic [1:0]  b_got;
    logic [31:0] exp_v [16];

    always #5 aclk = ~aclk;

    tvip_axi_ram_responder #(
        .DATA_WIDTH (32),
        .DEPTH      (1024),
        .BASE_ADDR  (32'h0)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awcache(awcache), .awprot(awprot), .awqos(awqos),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arcache(arcache), .arprot(arprot), .arqos(arqos),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int last_at,
                            input int b_stall);
        int n;
        logic [1:0] r0;
        awaddr = addr; awlen = len; awsize = size; awburst = tvip_axi_burst_type'(burst);
        awid = id; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        chk("awready", awready, 1);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == last_at); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin tick(); n++; end
            chk($sformatf("wready_%0d", i), wready, 1);
            if (i == 0) chk("awready_in_data", awready, 0);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        chk("bvalid", bvalid, 1);
        chk("bid", bid, id);
        for (int k = 0; k < b_stall; k++) begin
            r0 = bresp;
            tick();
            chk("b_stall_valid", bvalid, 1);
            chk("b_stall_resp", bresp, r0);
            chk("b_stall_awready", awready, 0);
        end
        b_got = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit toggle);
        int n;
        logic [31:0] d0;
        logic [1:0]  p0;
        logic        l0;
        araddr = addr; arlen = len; arsize = size; arburst = tvip_axi_burst_type'(burst);
        arid = id; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        chk("arready", arready, 1);
        tick();
        arvalid = 1'b0;
        chk("rvalid_after_ar", rvalid, 1);
        if (!toggle) rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!rvalid && n < 50) begin tick(); n++; end
            chk($sformatf("rvalid_%0d", i), rvalid, 1);
            chk($sformatf("rid_%0d", i), rid, id);
            if (toggle) begin
                d0 = rdata; p0 = rresp; l0 = rlast;
                rready = 1'b0;
                tick();
                chk("r_stall_valid", rvalid, 1);
                chk("r_stall_data", rdata, d0);
                chk("r_stall_resp", rresp, p0);
                chk("r_stall_last", rlast, l0);
                rready = 1'b1;
            end
            rbuf[i] = rdata; rrespbuf[i] = rresp; rlastbuf[i] = rlast;
            tick();
            if (toggle) rready = 1'b0;
        end
        rready = 1'b0;
        chk("rvalid_end", rvalid, 0);
    endtask

    task automatic check_read(input string tag, input int len, input logic [1:0] resp);
        for (int i = 0; i <= len; i++) begin
            chk($sformatf("%s_data_%0d", tag, i), rbuf[i], exp_v[i]);
            chk($sformatf("%s_resp_%0d", tag, i), rrespbuf[i], resp);
            chk($sformatf("%s_last_%0d", tag, i), rlastbuf[i], (i == len));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = TVIP_AXI_FIXED_BURST;
        awcache = 0; awprot = 0; awqos = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = TVIP_AXI_FIXED_BURST;
        arcache = 0; arprot = 0; arqos = 0; rready = 0;
        tick(); tick();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_outs", {bid, bresp, rid, rdata, rresp, rlast}, '0);
        areset = 1'b0;
        tick(); tick();

        // single write then read
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(32'h10, 8'd0, 3'd2, 2'b01, 4'd3, 0, 0);
        chk("single_bresp", b_got, 2'b00);
        do_read(32'h10, 8'd0, 3'd2, 2'b01, 4'd5, 1'b0);
        exp_v[0] = 32'hDEADBEEF;
        check_read("single", 0, 2'b00);

        // words 0/1 for the out-of-range check, 0x28 pre-filled for the strobe check
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(32'h0, 8'd1, 3'd2, 2'b01, 4'd1, 1, 0);
        chk("w01_bresp", b_got, 2'b00);
        wbuf[0] = 32'hFFFFFFFF;
        do_write(32'h28, 8'd0, 3'd2, 2'b01, 4'd2, 0, 0);

        // INCR 4-beat with strobes
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        sbuf[2] = 4'h3;
        do_write(32'h20, 8'd3, 3'd2, 2'b01, 4'd7, 3, 0);
        chk("incr_bresp", b_got, 2'b00);
        do_read(32'h20, 8'd3, 3'd2, 2'b01, 4'd9, 1'b0);
        exp_v[0] = 32'd1; exp_v[1] = 32'd2; exp_v[2] = 32'hFFFF0003; exp_v[3] = 32'd4;
        check_read("incr", 3, 2'b00);

        // FIXED read repeats one word
        do_read(32'h10, 8'd1, 3'd2, 2'b00, 4'd4, 1'b0);
        exp_v[0] = 32'hDEADBEEF; exp_v[1] = 32'hDEADBEEF;
        check_read("fixed", 1, 2'b00);

        // WRAP: beats hit 0x38,0x3C,0x30,0x34
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
        do_write(32'h38, 8'd3, 3'd2, 2'b10, 4'd6, 3, 0);
        chk("wrap_bresp", b_got, 2'b00);
        do_read(32'h30, 8'd3, 3'd2, 2'b01, 4'd6, 1'b0);
        exp_v[0] = 32'hA2; exp_v[1] = 32'hA3; exp_v[2] = 32'hA0; exp_v[3] = 32'hA1;
        check_read("wrap_lin", 3, 2'b00);
        do_read(32'h38, 8'd3, 3'd2, 2'b10, 4'd6, 1'b0);
        exp_v[0] = 32'hA0; exp_v[1] = 32'hA1; exp_v[2] = 32'hA2; exp_v[3] = 32'hA3;
        check_read("wrap_rd", 3, 2'b00);

        // misaligned WRAP: SLVERR, no RAM update
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hE0 + 32'(i);
        do_write(32'h3A, 8'd3, 3'd2, 2'b10, 4'd8, 3, 0);
        chk("wrap_bad_bresp", b_got, 2'b10);
        do_read(32'h30, 8'd3, 3'd2, 2'b01, 4'd8, 1'b0);
        exp_v[0] = 32'hA2; exp_v[1] = 32'hA3; exp_v[2] = 32'hA0; exp_v[3] = 32'hA1;
        check_read("wrap_unchanged", 3, 2'b00);
        do_read(32'h3A, 8'd3, 3'd2, 2'b10, 4'd8, 1'b0);
        for (int i = 0; i < 4; i++) exp_v[i] = 32'h0;
        check_read("wrap_bad_rd", 3, 2'b10);

        // oversize beat and reserved burst type
        wbuf[0] = 32'h55555555;
        do_write(32'h10, 8'd0, 3'd3, 2'b01, 4'd2, 0, 0);
        chk("size_bresp", b_got, 2'b10);
        do_read(32'h10, 8'd0, 3'd2, 2'b01, 4'd2, 1'b0);
        exp_v[0] = 32'hDEADBEEF;
        check_read("size_unchanged", 0, 2'b00);
        do_read(32'h20, 8'd1, 3'd2, 2'b11, 4'd2, 1'b0);
        exp_v[0] = 32'h0; exp_v[1] = 32'h0;
        check_read("rsvd_burst", 1, 2'b10);

        // early wlast forces SLVERR
        wbuf[0] = 32'h77; wbuf[1] = 32'h78;
        do_write(32'h80, 8'd1, 3'd2, 2'b01, 4'd1, 0, 0);
        chk("wlast_bresp", b_got, 2'b10);

        // backpressure: B held 5 cycles, 8-beat read with rready toggling
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hB0000000 + 32'(i); sbuf[i] = 4'hF; end
        do_write(32'h100, 8'd7, 3'd2, 2'b01, 4'hA, 7, 5);
        chk("bp_bresp", b_got, 2'b00);
        do_read(32'h100, 8'd7, 3'd2, 2'b01, 4'hB, 1'b1);
        for (int i = 0; i < 8; i++) exp_v[i] = 32'hB0000000 + 32'(i);
        check_read("bp", 7, 2'b00);

        // reset after 2 of 4 W beats
        awaddr = 32'h200; awlen = 8'd3; awsize = 3'd2; awburst = TVIP_AXI_INCREMENTING_BURST;
        awid = 4'd3; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'hDEAD0000 + 32'(i); wstrb = 4'hF; wvalid = 1'b1;
            tick();
        end
        wvalid = 1'b0;
        areset = 1'b1;
        tick();
        chk("mid_rst_ready_valid", {awready, wready, bvalid, arready, rvalid}, 5'b0);
        areset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF; end
        do_write(32'h200, 8'd3, 3'd2, 2'b01, 4'd3, 3, 0);
        chk("post_rst_bresp", b_got, 2'b00);
        do_read(32'h200, 8'd3, 3'd2, 2'b01, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) exp_v[i] = 32'hC0 + 32'(i);
        check_read("post_rst", 3, 2'b00);

        // just past the RAM window
        do_read(32'h1000, 8'd1, 3'd2, 2'b01, 4'd1, 1'b0);
`ifdef TVIP_AXI_RAM_RESPONDER_DECERR_EN
        exp_v[0] = 32'h0; exp_v[1] = 32'h0;
        check_read("oor", 1, 2'b11);
`else
        exp_v[0] = 32'h11111111; exp_v[1] = 32'h22222222;
        check_read("oor", 1, 2'b00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
